wb_interconnect_n: RTL and testbench

Parametrised single-master, N-slave Wishbone interconnect. It replaces the fixed four-way slave arbiter (BRAM/BROM/SDRAM/MMAP) between the CPU Wishbone master and the memory and peripheral slaves. Base/mask decode per slave, registered request forwarding, bus-error on unmapped addresses, per-transaction timeout watchdog and abort on master cycle drop. One transaction outstanding at a time.

---
 rtl/wb_interconnect_n.sv | 197 +++++++++++++++++++
 tb/tb_wb_interconnect_n.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_n.sv
// Single-master, N-slave Wishbone interconnect.
// Base/mask address decode (lowest index wins), registered request forwarding,
// bus error on unmapped addresses, per-transaction timeout and master-abort handling.
// Only one transaction is outstanding at any time.
module wb_interconnect_n #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE =
    {32'hF000_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK =
    {32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // master side
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [AW-1:0]          i_wb_addr,
  input  logic [DW-1:0]          i_wb_data,
  input  logic [DW/8-1:0]        i_wb_sel,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic                   o_wb_err,
  output logic [DW-1:0]          o_wb_data,
  // slave side
  output logic [N_SLAVES-1:0]    o_s_cyc,
  output logic [N_SLAVES-1:0]    o_s_stb,
  output logic                   o_s_we,
  output logic [AW-1:0]          o_s_addr,
  output logic [DW-1:0]          o_s_data,
  output logic [DW/8-1:0]        o_s_sel,
  input  logic [N_SLAVES-1:0]    i_s_stall,
  input  logic [N_SLAVES-1:0]    i_s_ack,
  input  logic [N_SLAVES*DW-1:0] i_s_data,
  // diagnostics
  output logic [AW-1:0]          o_err_addr
);

  localparam int unsigned IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StErr} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   addr_q;
  logic [TO_W-1:0] cnt_q;

  logic                hit;
  logic [IW-1:0]       hit_idx;
  logic [AW-1:0]       hit_mask;
  logic [N_SLAVES-1:0] hit_onehot;

  logic          sel_ack;
  logic          sel_stall;
  logic [DW-1:0] sel_data;

  logic [TO_W:0] cnt_inc;
  logic          timed_out;

  // Address decode; scanning downwards lets the lowest matching index win.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_mask   = '0;
    hit_onehot = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((i_wb_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
        hit           = 1'b1;
        hit_idx       = i[IW-1:0];
        hit_mask      = SLAVE_MASK[i*AW +: AW];
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  // Response signals of the currently selected slave; all others are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_stall = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx_q == i[IW-1:0]) begin
        sel_ack   = i_s_ack[i];
        sel_stall = i_s_stall[i];
        sel_data  = i_s_data[i*DW +: DW];
      end
    end
  end

  // Timeout fires on the TIMEOUT-th cycle spent in REQ/WAIT.
  always_comb begin
    cnt_inc   = {1'b0, cnt_q} + 1'b1;
    timed_out = (cnt_inc == TO_LIM);
  end

  // Transaction FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      o_wb_stall <= 1'b0;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wb_data  <= '0;
      o_s_cyc    <= '0;
      o_s_stb    <= '0;
      o_s_we     <= 1'b0;
      o_s_addr   <= '0;
      o_s_data   <= '0;
      o_s_sel    <= '0;
      o_err_addr <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_wb_cyc && i_wb_stb) begin
            o_wb_stall <= 1'b1;
            o_s_we     <= i_wb_we;
            o_s_data   <= i_wb_data;
            o_s_sel    <= i_wb_sel;
            addr_q     <= i_wb_addr;
            if (hit) begin
              idx_q    <= hit_idx;
              o_s_addr <= i_wb_addr & ~hit_mask;
              o_s_cyc  <= hit_onehot;
              o_s_stb  <= hit_onehot;
              cnt_q    <= '0;
              state_q  <= StReq;
            end else begin
              o_s_addr   <= i_wb_addr;
              o_err_addr <= i_wb_addr;
              o_wb_err   <= 1'b1;
              state_q    <= StErr;
            end
          end
        end

        StReq, StWait: begin
          if (!i_wb_cyc) begin
            // Master abort beats ack and timeout: release the slave silently.
            o_s_cyc    <= '0;
            o_s_stb    <= '0;
            o_wb_stall <= 1'b0;
            state_q    <= StIdle;
          end else if (sel_ack && (state_q == StWait || !sel_stall)) begin
            o_s_cyc   <= '0;
            o_s_stb   <= '0;
            o_wb_data <= sel_data;
            o_wb_ack  <= 1'b1;
            state_q   <= StResp;
          end else if (timed_out) begin
            o_s_cyc    <= '0;
            o_s_stb    <= '0;
            o_err_addr <= addr_q;
            o_wb_err   <= 1'b1;
            state_q    <= StErr;
          end else begin
            cnt_q <= cnt_inc[TO_W-1:0];
            if (state_q == StReq && !sel_stall) begin
              o_s_stb <= '0;
              state_q <= StWait;
            end
          end
        end

        StResp: begin
          o_wb_ack   <= 1'b0;
          o_wb_stall <= 1'b0;
          state_q    <= StIdle;
        end

        StErr: begin
          o_wb_err   <= 1'b0;
          o_wb_stall <= 1'b0;
          state_q    <= StIdle;
        end

        default: begin
          o_s_cyc    <= '0;
          o_s_stb    <= '0;
          o_wb_ack   <= 1'b0;
          o_wb_err   <= 1'b0;
          o_wb_stall <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Self-checking bench for wb_interconnect_n: random transactions against a
// transaction-level model of decode, slave timing, timeout and abort outcomes.
module tb_wb_interconnect_n;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 255;

  localparam logic [31:0] BASES [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h8000_0000,
                                         32'hF000_0000};
  localparam logic [31:0] MASKS [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000,
                                         32'hFFFF_0000};

  localparam int NEVER = 1_000_000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]    i_wb_addr, i_wb_data;
  logic [3:0]     i_wb_sel;
  logic           o_wb_stall, o_wb_ack, o_wb_err;
  logic [31:0]    o_wb_data;
  logic [NS-1:0]  o_s_cyc, o_s_stb;
  logic           o_s_we;
  logic [31:0]    o_s_addr, o_s_data;
  logic [3:0]     o_s_sel;
  logic [NS-1:0]  i_s_stall, i_s_ack;
  logic [NS*32-1:0] i_s_data;
  logic [31:0]    o_err_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;

  logic [31:0] exp_data;
  logic [31:0] exp_err_addr;

  wb_interconnect_n #(
    .N_SLAVES (NS),
    .AW       (32),
    .DW       (32),
    .TIMEOUT  (TO),
    .TO_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_wb_sel   (i_wb_sel),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_err   (o_wb_err),
    .o_wb_data  (o_wb_data),
    .o_s_cyc    (o_s_cyc),
    .o_s_stb    (o_s_stb),
    .o_s_we     (o_s_we),
    .o_s_addr   (o_s_addr),
    .o_s_data   (o_s_data),
    .o_s_sel    (o_s_sel),
    .i_s_stall  (i_s_stall),
    .i_s_ack    (i_s_ack),
    .i_s_data   (i_s_data),
    .o_err_addr (o_err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Lowest-index window containing the address, or -1 when unmapped.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASKS[i]) == BASES[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [8];
    edges = '{32'h0000_FFFF, 32'h0002_0000, 32'h80FF_FFFF, 32'h8100_0000,
              32'hF001_0000, 32'hEFFF_FFFF, 32'h7FFF_FFFF, 32'h0001_FFFF};
    case ($urandom_range(0, 5))
      0:       return {16'h0000, 16'($urandom)};
      1:       return {16'h0001, 16'($urandom)};
      2:       return {8'h80, 24'($urandom)};
      3:       return {16'hF000, 16'($urandom)};
      4:       return edges[$urandom_range(0, 7)];
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, {o_wb_stall, o_wb_ack, o_wb_err, o_s_cyc, o_s_stb, o_s_we, o_s_sel},
             '0);
    check_eq({tag, "_rdata"}, o_wb_data, '0);
    check_eq({tag, "_saddr"}, o_s_addr, '0);
    check_eq({tag, "_sdata"}, o_s_data, '0);
    check_eq({tag, "_erraddr"}, o_err_addr, '0);
  endtask

  task automatic noise();
    i_s_ack   = NS'($urandom);
    i_s_stall = NS'($urandom);
    for (int j = 0; j < NS; j++) i_s_data[j*32 +: 32] = $urandom;
  endtask

  // One master transaction. Target slave stalls s cycles, then acks a cycles after
  // accepting stb (a < 0: never). d > 0: master drops cyc in cycle d.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] sel, input int s, input int a, input int d);
    int tgt, ack_cyc, lim, resp_at, cyc_exp, stb_exp, w;
    bit abort_wins, ack_wins, err_exp;
    int n_ack, ack_at, n_err, err_at, cyc_n, stb_n;
    bit stray;
    string p;

    txn_id++;
    p = $sformatf("t%0d", txn_id);
    tgt        = decode(addr);
    ack_cyc    = (a < 0) ? NEVER : s + 1 + a;
    abort_wins = 1'b0;
    ack_wins   = 1'b0;
    err_exp    = 1'b0;
    if (tgt < 0) begin
      err_exp = 1'b1; resp_at = 1; cyc_exp = 0; stb_exp = 0;
    end else begin
      lim = (ack_cyc < TO) ? ack_cyc : TO;
      if (d > 0 && d <= lim) begin
        abort_wins = 1'b1; resp_at = d; cyc_exp = d; stb_exp = (s + 1 < d) ? s + 1 : d;
      end else if (ack_cyc <= TO) begin
        ack_wins = 1'b1; resp_at = ack_cyc + 1; cyc_exp = ack_cyc; stb_exp = s + 1;
      end else begin
        err_exp = 1'b1; resp_at = TO + 1; cyc_exp = TO; stb_exp = (s + 1 < TO) ? s + 1 : TO;
      end
    end
    w = resp_at + 1;
    if (tgt >= 0 && ack_cyc != NEVER && ack_cyc + 1 > w) w = ack_cyc + 1;

    n_ack = 0; ack_at = 0; n_err = 0; err_at = 0; cyc_n = 0; stb_n = 0; stray = 1'b0;

    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = addr; i_wb_data = wdata; i_wb_sel = sel;
    noise();

    for (int c = 1; c <= w; c++) begin
      @(negedge clk);
      if (o_wb_ack) begin n_ack++; if (ack_at == 0) ack_at = c; end
      if (o_wb_err) begin n_err++; if (err_at == 0) err_at = c; end
      for (int j = 0; j < NS; j++) begin
        if (o_s_cyc[j]) begin if (j == tgt) cyc_n++; else stray = 1'b1; end
        if (o_s_stb[j]) begin if (j == tgt) stb_n++; else stray = 1'b1; end
      end
      if (c == 1) begin
        check_eq({p, "_stall_busy"}, o_wb_stall, 1'b1);
        if (tgt >= 0) begin
          check_eq({p, "_s_we"}, o_s_we, we);
          check_eq({p, "_s_addr"}, o_s_addr, addr & ~MASKS[tgt]);
          check_eq({p, "_s_data"}, o_s_data, wdata);
          check_eq({p, "_s_sel"}, o_s_sel, sel);
        end
      end
      if (c == w) check_eq({p, "_stall_idle"}, o_wb_stall, 1'b0);

      i_wb_stb = 1'b0;
      i_wb_cyc = abort_wins ? (c < d) : (c <= resp_at);
      noise();
      if (tgt >= 0) begin
        i_s_stall[tgt] = (c <= s);
        i_s_ack[tgt]   = (c == ack_cyc);
        if (c == ack_cyc && ack_wins) exp_data = i_s_data[tgt*32 +: 32];
      end
    end
    if (err_exp) exp_err_addr = addr;

    check_eq({p, "_ack_count"}, n_ack, ack_wins ? 1 : 0);
    check_eq({p, "_ack_cycle"}, ack_at, ack_wins ? resp_at : 0);
    check_eq({p, "_err_count"}, n_err, err_exp ? 1 : 0);
    check_eq({p, "_err_cycle"}, err_at, err_exp ? resp_at : 0);
    check_eq({p, "_cyc_cycles"}, cyc_n, cyc_exp);
    check_eq({p, "_stb_cycles"}, stb_n, stb_exp);
    check_eq({p, "_stray_sel"}, stray, 1'b0);
    check_eq({p, "_rdata"}, o_wb_data, exp_data);
    check_eq({p, "_err_addr"}, o_err_addr, exp_err_addr);
  endtask

  // Reset pulse while a request to slave 3 sits in REQ.
  task automatic reset_mid_txn();
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
    i_wb_addr = 32'hF000_0020; i_wb_data = $urandom; i_wb_sel = 4'hF;
    i_s_stall = '1; i_s_ack = '0;
    @(negedge clk);
    i_wb_stb = 1'b0;
    check_eq("rst_pre_cyc", o_s_cyc, 4'b1000);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    i_wb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_s_stall = '0;
    exp_data = '0;
    exp_err_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0;
    i_s_stall = '0; i_s_ack = '0; i_s_data = '0;
    exp_data = '0; exp_err_addr = '0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(32'h0001_0004, 1'b0, 32'h0, 4'hF, 0, 0, 0);           // zero-wait read
    run_txn(32'h0001_0008, 1'b0, 32'h0, 4'hF, 0, 1, 0);           // ack one cycle after stb
    run_txn(32'h8000_1230, 1'b1, 32'h1234_5678, 4'b0011, 3, 0, 0); // stalled write
    run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 0);           // unmapped
    run_txn(32'hF000_0010, 1'b0, 32'h0, 4'hF, 0, -1, 0);          // timeout
    run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 1, 0);           // recovery
    run_txn(32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 3, 3);           // abort in WAIT
    run_txn(32'h0001_0040, 1'b0, 32'h0, 4'hF, 2, 0, 2);           // abort in REQ
    reset_mid_txn();
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 0, 0, 0);
    run_txn(32'h8012_3456, 1'b1, 32'hCAFE_F00D, 4'hC, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int s, a, d;
      s = $urandom_range(0, 3);
      a = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
      d = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, s + 2)) : 0;
      run_txn(rand_addr(), 1'($urandom), $urandom, 4'($urandom), s, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
